// File: rtl/minmax_pkg.sv
// Shared types for the streaming min/max tracker.
package minmax_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} minmax_state_t;
endpackage

// File: rtl/comparator_lt.sv
// Signed two's-complement less-than: lt = (a < b). Combinational, no backpressure.
module comparator_lt #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         lt
);
   assign lt = $signed(a) < $signed(b);
endmodule

// File: rtl/stream_min_max.sv
// Tracks signed min/max (first-occurrence index) and count over one packet; result beat one cycle after in_last.
// in_ready is low while a result waits for out_ready, so the result register is never overwritten.
module stream_min_max
   import minmax_pkg::*;
#(
   parameter int N     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [N-1:0]     out_min,
   output logic [N-1:0]     out_max,
   output logic [CNT_W-1:0] out_min_idx,
   output logic [CNT_W-1:0] out_max_idx,
   output logic [CNT_W-1:0] out_count,
   output logic             out_valid,
   input  logic             out_ready
);
   minmax_state_t    state_q, state_nxt;
   logic             new_min, new_max;
   logic             take_first, take_acc;
   logic [CNT_W-1:0] count_inc;

   comparator_lt #(.N(N)) u_lt_min (.a(in_data), .b(out_min), .lt(new_min));
   comparator_lt #(.N(N)) u_gt_max (.a(out_max), .b(in_data), .lt(new_max));

   assign count_inc = (out_count == {CNT_W{1'b1}}) ? out_count : out_count + 1'b1;
   assign out_valid = (state_q == S_DONE);

   always_comb begin
      state_nxt  = state_q;
      in_ready   = 1'b0;
      take_first = 1'b0;
      take_acc   = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               take_first = 1'b1;
               state_nxt  = in_last ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               take_acc = 1'b1;
               if (in_last) state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // Reset overrides everything; in_ready never depends on in_valid.
      if (!rst) begin
         in_ready   = 1'b0;
         take_first = 1'b0;
         take_acc   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         out_min     <= '0;
         out_max     <= '0;
         out_min_idx <= '0;
         out_max_idx <= '0;
         out_count   <= '0;
      end else begin
         state_q <= state_nxt;
         if (take_first) begin
            out_min     <= in_data;
            out_max     <= in_data;
            out_min_idx <= '0;
            out_max_idx <= '0;
            out_count   <= {{(CNT_W-1){1'b0}}, 1'b1};
         end else if (take_acc) begin
            // Index uses the pre-increment count, so it saturates with the counter.
            if (new_min) begin
               out_min     <= in_data;
               out_min_idx <= out_count;
            end
            if (new_max) begin
               out_max     <= in_data;
               out_max_idx <= out_count;
            end
            out_count <= count_inc;
         end
      end
   end
endmodule

// File: tb/tb_stream_min_max.sv
// Directed bench for stream_min_max: main instance at CNT_W=16, second at CNT_W=4 for saturation.
module tb_stream_min_max;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid, in_last, in_ready;
   logic [31:0] out_min, out_max;
   logic [15:0] out_min_idx, out_max_idx, out_count;
   logic        out_valid, out_ready;

   logic [31:0] d4_data;
   logic        d4_valid, d4_last, d4_in_ready;
   logic [31:0] d4_min, d4_max;
   logic [3:0]  d4_min_idx, d4_max_idx, d4_count;
   logic        d4_out_valid, d4_out_ready;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] held_min, held_max;

   always #5 clk = ~clk;

   stream_min_max #(.N(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_min(out_min), .out_max(out_max), .out_min_idx(out_min_idx),
      .out_max_idx(out_max_idx), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
   );

   stream_min_max #(.N(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_data(d4_data), .in_valid(d4_valid), .in_last(d4_last),
      .in_ready(d4_in_ready), .out_min(d4_min), .out_max(d4_max), .out_min_idx(d4_min_idx),
      .out_max_idx(d4_max_idx), .out_count(d4_count), .out_valid(d4_out_valid), .out_ready(d4_out_ready)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send4(input logic [31:0] d, input logic last);
      d4_valid = 1'b1;
      d4_data  = d;
      d4_last  = last;
      @(posedge clk); #1;
      d4_valid = 1'b0;
      d4_last  = 1'b0;
   endtask

   task automatic consume;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [31:0] mn, input logic [15:0] mni,
                               input logic [31:0] mx, input logic [15:0] mxi, input logic [15:0] cnt);
      check_eq({tag, ".valid"},   out_valid, 1);
      check_eq({tag, ".min"},     out_min, mn);
      check_eq({tag, ".min_idx"}, out_min_idx, mni);
      check_eq({tag, ".max"},     out_max, mx);
      check_eq({tag, ".max_idx"}, out_max_idx, mxi);
      check_eq({tag, ".count"},   out_count, cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      d4_valid = 1'b0; d4_last = 1'b0; d4_data = '0; d4_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst.in_ready", in_ready, 0);
      check_eq("rst.out_valid", out_valid, 0);
      check_eq("rst.min", out_min, 0);
      check_eq("rst.count", out_count, 0);
      rst = 1'b1;
      #1;
      check_eq("idle.in_ready", in_ready, 1);

      // 1: mixed signs, ties keep first index
      send(32'd5, 0); send(32'hFFFF_FFFD, 0); send(32'd7, 0); send(32'hFFFF_FFFD, 0);
      check_eq("t1.valid_early", out_valid, 0);
      send(32'd2, 1);
      check_result("t1", 32'hFFFF_FFFD, 1, 32'd7, 2, 5);
      consume;
      check_eq("t1.valid_drop", out_valid, 0);
      check_eq("t1.idle_ready", in_ready, 1);

      // 2: single beat packet
      send(32'd42, 1);
      check_result("t2", 32'd42, 0, 32'd42, 0, 1);
      check_eq("t2.in_ready", in_ready, 0);
      consume;

      // 3: extremes of the signed range
      send(32'h7FFF_FFFF, 0); send(32'h8000_0000, 0); send(32'd0, 1);
      check_result("t3", 32'h8000_0000, 1, 32'h7FFF_FFFF, 0, 3);

      // 4: backpressure on the result while upstream keeps offering data
      held_min = 32'h8000_0000;
      held_max = 32'h7FFF_FFFF;
      in_valid = 1'b1; in_data = 32'd99; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_eq("t4.in_ready", in_ready, 0);
         @(posedge clk); #1;
         check_eq("t4.hold_min", out_min, held_min);
         check_eq("t4.hold_max", out_max, held_max);
         check_eq("t4.hold_valid", out_valid, 1);
      end
      check_eq("t4.hold_count", out_count, 3);
      in_valid = 1'b0; in_last = 1'b0;
      consume;
      check_eq("t4.valid_drop", out_valid, 0);
      check_eq("t4.idle_ready", in_ready, 1);
      send(32'd9, 1);
      check_result("t4b", 32'd9, 0, 32'd9, 0, 1);
      consume;

      // 5: reset mid-packet discards partial state
      send(32'd1, 0); send(32'd2, 0); send(32'd3, 0);
      rst = 1'b0;
      #1;
      check_eq("t5.rst_ready", in_ready, 0);
      @(posedge clk); #1;
      check_eq("t5.rst_valid", out_valid, 0);
      check_eq("t5.rst_min", out_min, 0);
      check_eq("t5.rst_max", out_max, 0);
      check_eq("t5.rst_count", out_count, 0);
      check_eq("t5.rst_max_idx", out_max_idx, 0);
      rst = 1'b1;
      send(32'hFFFF_FFF8, 0); send(32'd4, 1);
      check_result("t5", 32'hFFFF_FFF8, 0, 32'd4, 1, 2);
      consume;

      // 6: CNT_W=4 counter and index saturation
      for (int i = 0; i < 20; i++) send4(32'd0, 0);
      check_eq("t6.valid_early", d4_out_valid, 0);
      send4(32'hFFFF_FFFF, 1);
      check_eq("t6.valid", d4_out_valid, 1);
      check_eq("t6.count", d4_count, 15);
      check_eq("t6.min", d4_min, 32'hFFFF_FFFF);
      check_eq("t6.min_idx", d4_min_idx, 15);
      check_eq("t6.max", d4_max, 0);
      check_eq("t6.max_idx", d4_max_idx, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
